// File: rtl/snoop_pkg.sv
// snoop_pkg: shared encodings for the snooping coherence slice and write-back queue
package snoop_pkg;
  typedef enum logic [2:0] {
    INVALID  = 3'd0,
    SHARED   = 3'd1,
    MODIFIED = 3'd2
  } coh_state_e;
  typedef enum logic [2:0] {
    NONE    = 3'd0,
    RD_MISS = 3'd1,
    WR_MISS = 3'd2,
    INVAL   = 3'd3
  } bus_msg_e;
  localparam logic CACHE1 = 1'b0;
  localparam logic CACHE2 = 1'b1;
  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } drain_state_e;
endpackage

// File: rtl/snoop_wb_fifo.sv
// wb_fifo: write-back entry storage with a 2-wide push port and a 1-wide pop port
module wb_fifo
  import snoop_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       push,
  input  logic [TAG_W-1:0] tag1,
  input  logic [TAG_W-1:0] tag2,
  input  logic             pop,
  output logic             head_id,
  output logic [TAG_W-1:0] head_tag,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    count_nxt
);
  logic [TAG_W:0] mem [DEPTH];
  logic [AW-1:0] wp, rp, wp2;
  assign wp2 = push[0] ? wp + AW'(1) : wp;
  assign count_nxt = count + CW'(push[0]) + CW'(push[1]) - CW'(pop);
  assign {head_id, head_tag} = mem[rp];
  // cache 1 lands first (closer to head); cache 2 takes the following slot when both push
  always_ff @(posedge clk) begin
    if (rst_n && push[0]) mem[wp] <= {CACHE1, tag1};
    if (rst_n && push[1]) mem[wp2] <= {CACHE2, tag2};
  end
  // pointers wrap modulo DEPTH; count tells full from empty
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(push[0]) + AW'(push[1]);
      rp <= rp + AW'(pop);
      count <= count_nxt;
    end
  end
endmodule

// File: rtl/snoop_wb_queue.sv
// snoop_wb_queue: buffers coherence write-backs and drains them to memory over req/ack
module snoop_wb_queue
  import snoop_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [1:0]       WriteBack,
  input  logic [TAG_W-1:0] Tag1,
  input  logic [TAG_W-1:0] Tag2,
  output logic             Stall,
  output logic             MemReq,
  output logic             MemCacheId,
  output logic [TAG_W-1:0] MemTag,
  input  logic             MemAck,
  output logic [CW-1:0]    Count,
  output logic             DropErr
);
  drain_state_e state, state_nxt;
  logic [1:0] push;
  logic pop, head_id;
  logic [TAG_W-1:0] head_tag;
  logic [CW-1:0] count_nxt;
  assign push = Stall ? 2'b00 : WriteBack;
  assign pop = (state == REQ) && MemAck;
  wb_fifo #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_fifo (
    .clk(Clock),
    .rst_n(Reset_n),
    .push(push),
    .tag1(Tag1),
    .tag2(Tag2),
    .pop(pop),
    .head_id(head_id),
    .head_tag(head_tag),
    .count(Count),
    .count_nxt(count_nxt)
  );
  // drain FSM: request the head whenever idle with data, drop back to idle after each ack
  always_comb begin
    state_nxt = state;
    MemReq = state == REQ;
    MemCacheId = (state == REQ) ? head_id : 1'b0;
    MemTag = (state == REQ) ? head_tag : '0;
    state_nxt = (state == IDLE) ? ((Count != '0) ? REQ : IDLE) : (MemAck ? IDLE : REQ);
  end
  // state register plus registered stall (from post-edge occupancy) and sticky drop flag
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state <= IDLE;
      Stall <= 1'b0;
      DropErr <= 1'b0;
    end else begin
      state <= state_nxt;
      Stall <= count_nxt > CW'(DEPTH - 2);
      DropErr <= DropErr | (Stall & |WriteBack);
    end
  end
endmodule

// File: tb/tb_snoop_wb_queue.sv
// tb_snoop_wb_queue: directed stimulus checked by a queue-level model and literal expectations
module tb_snoop_wb_queue;
  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic [1:0] WriteBack = 2'b00;
  logic [3:0] Tag1 = 4'd0, Tag2 = 4'd0;
  logic       MemAck = 1'b0;
  logic       Stall, MemReq, MemCacheId, DropErr;
  logic [3:0] MemTag;
  logic [2:0] Count;
  int checks = 0, errors = 0;
  snoop_wb_queue #(.DEPTH(4), .TAG_W(4)) dut (
    .Clock(Clock),
    .Reset_n(Reset_n),
    .WriteBack(WriteBack),
    .Tag1(Tag1),
    .Tag2(Tag2),
    .Stall(Stall),
    .MemReq(MemReq),
    .MemCacheId(MemCacheId),
    .MemTag(MemTag),
    .MemAck(MemAck),
    .Count(Count),
    .DropErr(DropErr)
  );
  always #5 Clock = ~Clock;
  // behavioural model: a plain queue of {id,tag}, a request flag and a sticky drop flag
  logic [4:0] q[$];
  bit mreq = 0, mdrop = 0, armed = 0, st, nr;
  always @(posedge Clock) begin
    if (!Reset_n) begin
      q.delete();
      mreq = 0;
      mdrop = 0;
      armed = 1;
    end else begin
      st = q.size() > 2;
      nr = mreq ? !MemAck : (q.size() != 0);
      if (WriteBack != 2'b00 && st) mdrop = 1;
      if (mreq && MemAck) void'(q.pop_front());
      if (!st) begin
        if (WriteBack[0]) q.push_back({1'b0, Tag1});
        if (WriteBack[1]) q.push_back({1'b1, Tag2});
      end
      mreq = nr;
    end
  end
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  // compare process: every cycle once the model has seen reset
  always @(negedge Clock) begin
    if (armed) begin
      chk("m_count", int'(Count), q.size());
      chk("m_memreq", int'(MemReq), int'(mreq));
      chk("m_stall", int'(Stall), int'(q.size() > 2));
      chk("m_droperr", int'(DropErr), int'(mdrop));
      if (mreq && q.size() != 0) begin
        chk("m_id", int'(MemCacheId), int'(q[0][4]));
        chk("m_tag", int'(MemTag), int'(q[0][3:0]));
      end
    end
  end
  task automatic cyc();
    @(negedge Clock);
  endtask
  task automatic drain_one(input logic eid, input logic [3:0] etag, output int waits);
    waits = 0;
    while (!MemReq && waits < 8) begin
      cyc();
      waits++;
    end
    if (!MemReq) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: MemReq low after %0d cycles, expected high", waits);
      return;
    end
    chk("drain_id", int'(MemCacheId), int'(eid));
    chk("drain_tag", int'(MemTag), int'(etag));
    MemAck = 1'b1;
    cyc();
    MemAck = 1'b0;
    chk("idle_after_ack", int'(MemReq), 0);
  endtask
  initial begin
    int w;
    logic [3:0] tv;
    cyc();
    cyc();
    Reset_n = 1'b1;
    chk("rst_count", int'(Count), 0);
    chk("rst_memreq", int'(MemReq), 0);
    chk("rst_stall", int'(Stall), 0);
    chk("rst_droperr", int'(DropErr), 0);
    chk("rst_id", int'(MemCacheId), 0);
    chk("rst_tag", int'(MemTag), 0);
    WriteBack = 2'b01; Tag1 = 4'd5;
    cyc();
    WriteBack = 2'b00;
    chk("single_count", int'(Count), 1);
    chk("single_noreq_yet", int'(MemReq), 0);
    cyc();
    chk("single_req", int'(MemReq), 1);
    chk("single_id", int'(MemCacheId), 0);
    chk("single_tag", int'(MemTag), 5);
    MemAck = 1'b1;
    cyc();
    MemAck = 1'b0;
    chk("single_popped", int'(Count), 0);
    chk("single_req_low", int'(MemReq), 0);
    WriteBack = 2'b11; Tag1 = 4'd3; Tag2 = 4'd9;
    cyc();
    WriteBack = 2'b00;
    chk("dual_count", int'(Count), 2);
    drain_one(1'b0, 4'd3, w);
    chk("dual_wait1", w, 1);
    drain_one(1'b1, 4'd9, w);
    chk("dual_gap", w, 1);
    WriteBack = 2'b11; Tag1 = 4'd1; Tag2 = 4'd2;
    cyc();
    Tag1 = 4'd3; Tag2 = 4'd4;
    cyc();
    chk("bp_count", int'(Count), 4);
    chk("bp_stall", int'(Stall), 1);
    chk("bp_req", int'(MemReq), 1);
    WriteBack = 2'b01; Tag1 = 4'd7;
    cyc();
    WriteBack = 2'b00;
    chk("bp_nopush", int'(Count), 4);
    chk("bp_drop", int'(DropErr), 1);
    drain_one(1'b0, 4'd1, w);
    chk("bp_count3", int'(Count), 3);
    chk("bp_stall3", int'(Stall), 1);
    drain_one(1'b1, 4'd2, w);
    chk("bp_count2", int'(Count), 2);
    chk("bp_stall2", int'(Stall), 0);
    drain_one(1'b0, 4'd3, w);
    drain_one(1'b1, 4'd4, w);
    WriteBack = 2'b01; Tag1 = 4'd6;
    cyc();
    WriteBack = 2'b00;
    cyc();
    chk("pp_req", int'(MemReq), 1);
    chk("pp_count1", int'(Count), 1);
    MemAck = 1'b1; WriteBack = 2'b10; Tag2 = 4'd11;
    cyc();
    MemAck = 1'b0; WriteBack = 2'b00;
    chk("pp_count", int'(Count), 1);
    chk("pp_req_low", int'(MemReq), 0);
    drain_one(1'b1, 4'd11, w);
    for (int i = 0; i < 10; i++) begin
      tv = 4'(i * 3 + 1);
      WriteBack = 2'b01; Tag1 = tv;
      cyc();
      WriteBack = 2'b00;
      drain_one(1'b0, tv, w);
    end
    chk("wrap_empty", int'(Count), 0);
    WriteBack = 2'b11; Tag1 = 4'd12; Tag2 = 4'd13;
    cyc();
    WriteBack = 2'b01; Tag1 = 4'd14;
    cyc();
    WriteBack = 2'b00;
    chk("mid_count", int'(Count), 3);
    chk("mid_req", int'(MemReq), 1);
    chk("mid_drop_before", int'(DropErr), 1);
    Reset_n = 1'b0; MemAck = 1'b1;
    cyc();
    Reset_n = 1'b1;
    chk("mid_rst_req", int'(MemReq), 0);
    chk("mid_rst_count", int'(Count), 0);
    chk("mid_rst_drop", int'(DropErr), 0);
    chk("mid_rst_stall", int'(Stall), 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("ack_ignored_req", int'(MemReq), 0);
      chk("ack_ignored_count", int'(Count), 0);
    end
    MemAck = 1'b0;
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/snoop_wb_queue.md
# snoop_wb_queue

Write-back queue sitting directly downstream of the snooping coherence state machines. It captures the per-cache `WriteBack` requests produced when a Modified block is evicted or snooped, buffers them in a small FIFO, and drains them one at a time to the memory side over a req/ack handshake. While it is near full it back-pressures the coherence stage through `Stall`.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `TAG_W`, 4: block tag width carried with each request.
- `Clock`  in  1  single clock; all state changes on its rising edge.
- `Reset_n`  in  1  synchronous, active-low reset.
- `WriteBack`  in  2  bit0 = cache 1 requests write-back, bit1 = cache 2; both may be set together.
- `Tag1`, `Tag2`  in  TAG_W  block tag of cache 1 / cache 2, valid with the matching `WriteBack` bit.
- `Stall`  out  1  registered; high when Count > DEPTH−2; the upstream stage must hold `WriteBack` while high.
- `MemReq`  out  1  request valid toward memory.
- `MemCacheId`  out  1  0 = cache 1, 1 = cache 2 (head entry).
- `MemTag`  out  TAG_W  tag of head entry.
- `MemAck`  in  1  memory accepted current request; meaningful only while `MemReq` is high.
- `Count`  out  $clog2(DEPTH)+1  current occupancy.
- `DropErr`  out  1  sticky; set if `WriteBack` is nonzero while `Stall` is high.

## Operation
- Enqueue: at a rising edge with `Stall` low, each set `WriteBack` bit pushes one entry {id, tag}. When both are set, cache 1 is pushed first (closer to head), then cache 2. Because `Stall` guarantees at least 2 free slots, an accepted push never overflows.
- `WriteBack` seen while `Stall` is high is ignored, and `DropErr` sets. `DropErr` clears only on reset.
- The drain FSM has two states:
  - IDLE: `MemReq`=0. Goes to REQ at the next edge if Count ≠ 0.
  - REQ: `MemReq`=1, and `MemCacheId`/`MemTag` show the head and stay stable. On an edge with `MemAck`=1 the head is popped and the FSM returns to IDLE. With `MemAck`=0 it stays in REQ.
- Push and pop at the same edge are both performed. Count changes by pushes minus the pop (range −1..+2).
- Read and write pointers are `$clog2(DEPTH)` bits and wrap naturally modulo DEPTH. Count distinguishes full from empty.
- `MemAck` in IDLE is ignored.

## Timing
- Reset (`Reset_n` low at an edge) sets Count=0, both pointers to 0, FSM=IDLE, `MemReq`=0, `Stall`=0, `DropErr`=0, and `MemCacheId`/`MemTag`=0. Reset takes priority over any simultaneous push, pop, or ack. A request in flight is abandoned, and `MemReq` is low from the cycle after the reset edge.
- Latency: an entry pushed at edge N is reflected in Count after N. The FSM enters REQ at N+1, so `MemReq` is high during the cycle after N+1 (2 cycles from push to request).
- Back-to-back: after a pop, `MemReq` is low for exactly one cycle (IDLE) before the next request. Peak drain is therefore one entry per 2 cycles.
- `Stall` is computed from Count after the edge, so it reflects same-edge pushes and pops with no extra delay.
- `DropErr` is set on the same edge where the offending `WriteBack` is sampled.

## Structure
- A shared package `snoop_pkg` holds:
  - coherence state encodings (3-bit: INVALID=0, SHARED=1, MODIFIED=2);
  - bus message encodings (3-bit: NONE=0, RD_MISS=1, WR_MISS=2, INVAL=3);
  - cache id constants CACHE1=0, CACHE2=1;
  - the drain FSM state typedef.
- One sub-module, `wb_fifo`: a parameterised storage array holding pointers and Count, with a 2-wide push port and a 1-wide pop port. The drain FSM, `Stall`, and `DropErr` live in `snoop_wb_queue`.

## Test plan
- Reset then single push: `WriteBack`=01, `Tag1`=5 at edge 1 → Count=1 after edge 1. `MemReq`=1 with id=0, tag=5 after edge 2. `MemAck` at edge 3 → Count=0 and `MemReq`=0.
- Dual push: `WriteBack`=11, `Tag1`=3, `Tag2`=9 → Count=2. Drain order is (0,3) then (1,9), with one idle cycle between the requests.
- Back-pressure, DEPTH=4: push 11 twice, so Count=4 and `Stall`=1. `WriteBack`=01 while stalled → no push and `DropErr`=1. Ack once → Count=3, `Stall` stays 1. Ack again → Count=2, `Stall`=0.
- Simultaneous push and pop: with Count=1 in REQ, `MemAck`=1 and `WriteBack`=10 at the same edge → Count stays 1, and the new head is the cache 2 entry.
- Wrap-around: 10 single pushes each drained with immediate ack → all tags exit in order and pointers wrap twice without error.
- Reset mid-operation: Count=3, `MemReq`=1, `Reset_n`=0 for one edge → next cycle `MemReq`=0, Count=0, `DropErr`=0, and ack pulses afterwards are ignored.
